// File: rtl/axi_lite_pkg.sv
// Shared constants, types and helpers for the AXI4-Lite memory slave.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [1:0] resp_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rstate_t;

  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi_lite_bytemem.sv
// Word-organised register memory with byte-enabled writes and a registered read port.
module axi_lite_bytemem
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int IDX_W      = clog2(DEPTH_WORDS)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic                  re,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  // Non-blocking read and write on the same edge give read-before-write on a collision.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (wstrb[k]) begin
            mem[widx][8*k +: 8] <= wdata[8*k +: 8];
          end
        end
      end
      if (re) begin
        rdata <= mem[ridx];
      end
    end
  end

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite slave over a byte-lane memory: independent AW/W capture, back-pressured B/R, SLVERR out of range.
module axi_lite_mem_slave
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 16,
  localparam int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic [STRB_W-1:0]     WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY
);

  localparam int ADDR_LSB = clog2(STRB_W);
  localparam int IDX_W    = clog2(DEPTH_WORDS);

  logic                  aw_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic                  w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  resp_t                 bresp;
  rstate_t               rstate;
  resp_t                 rresp;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic aw_in_range;
  logic ar_in_range;

  // Any address bit above the word index makes the access out of range.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> (ADDR_LSB + IDX_W)) == '0;
  endfunction

  assign AWREADY = !aw_full && !BVALID && !ARESET;
  assign WREADY  = !w_full && !BVALID && !ARESET;
  assign ARREADY = (rstate == R_IDLE) && !ARESET;

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = aw_full && w_full && !BVALID;

  assign aw_in_range = addr_in_range(aw_addr);
  assign ar_in_range = addr_in_range(ARADDR);

  assign BRESP  = bresp;
  assign RRESP  = rresp;
  assign RVALID = (rstate == R_VALID);
  assign RDATA  = (rresp == RESP_SLVERR) ? '0 : mem_rdata;

  // Capture and commit never coincide: a full holding register drops its own READY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      aw_addr <= '0;
      w_full  <= 1'b0;
      w_data  <= '0;
      w_strb  <= '0;
      BVALID  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        BVALID  <= 1'b1;
        bresp   <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (BVALID && BREADY) begin
        BVALID <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate <= R_IDLE;
      rresp  <= RESP_OKAY;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ARVALID) begin
            rstate <= R_VALID;
            rresp  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_VALID: begin
          if (RREADY) begin
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  axi_lite_bytemem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .ACLK  (ACLK),
    .ARESET(ARESET),
    .we    (commit && aw_in_range),
    .widx  (aw_addr[ADDR_LSB +: IDX_W]),
    .wdata (w_data),
    .wstrb (w_strb),
    .re    (ar_hs && ar_in_range),
    .ridx  (ARADDR[ADDR_LSB +: IDX_W]),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Directed self-checking bench for axi_lite_mem_slave (32-bit data, 16 words).
module tb_axi_lite_mem_slave;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int DEPTH_WORDS = 16;
  localparam int LIMIT       = 20;

  logic                  ACLK = 1'b0;
  logic                  ARESET;
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  int tests_run    = 0;
  int tests_failed = 0;

  axi_lite_mem_slave #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH_WORDS(DEPTH_WORDS)
  ) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .AWADDR (AWADDR),
    .AWVALID(AWVALID),
    .AWREADY(AWREADY),
    .WDATA  (WDATA),
    .WSTRB  (WSTRB),
    .WVALID (WVALID),
    .WREADY (WREADY),
    .BRESP  (BRESP),
    .BVALID (BVALID),
    .BREADY (BREADY),
    .ARADDR (ARADDR),
    .ARVALID(ARVALID),
    .ARREADY(ARREADY),
    .RDATA  (RDATA),
    .RRESP  (RRESP),
    .RVALID (RVALID),
    .RREADY (RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic applyStimulus(input logic bready, input logic rready);
    AWVALID = 1'b0;
    AWADDR  = '0;
    WVALID  = 1'b0;
    WDATA   = '0;
    WSTRB   = '0;
    ARVALID = 1'b0;
    ARADDR  = '0;
    BREADY  = bready;
    RREADY  = rready;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int   n;
    logic aw_done;
    logic w_done;
    AWADDR  = addr;
    AWVALID = 1'b1;
    WDATA   = data;
    WSTRB   = strb;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    n = 0;
    while ((AWVALID || WVALID) && n < LIMIT) begin
      aw_done = AWVALID && AWREADY;
      w_done  = WVALID && WREADY;
      tick();
      n++;
      if (aw_done) AWVALID = 1'b0;
      if (w_done) WVALID = 1'b0;
    end
    while (!BVALID && n < LIMIT) begin
      tick();
      n++;
    end
    checkOutput($sformatf("write_done_%0h", addr), (n < LIMIT) ? 64'd1 : 64'd0, 64'd1);
    resp = BRESP;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int   n;
    logic ar_done;
    ARADDR  = addr;
    ARVALID = 1'b1;
    RREADY  = 1'b1;
    n = 0;
    while (ARVALID && n < LIMIT) begin
      ar_done = ARREADY;
      tick();
      n++;
      if (ar_done) ARVALID = 1'b0;
    end
    while (!RVALID && n < LIMIT) begin
      tick();
      n++;
    end
    checkOutput($sformatf("read_done_%0h", addr), (n < LIMIT) ? 64'd1 : 64'd0, 64'd1);
    data = RDATA;
    resp = RRESP;
    tick();
    ARVALID = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    ARESET = 1'b1;
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("reset_handshake_outputs", {AWREADY, WREADY, ARREADY, BVALID, RVALID}, 5'b00000);
    checkOutput("reset_resps", {BRESP, RRESP}, 4'b0000);
    checkOutput("reset_rdata", RDATA, 32'h0);
    ARESET = 1'b0;
    #1;
    checkOutput("post_reset_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

    // Same-cycle AW/W: capture edge, then commit edge raises BVALID.
    AWADDR  = 32'h08;
    AWVALID = 1'b1;
    WDATA   = 32'hDEADBEEF;
    WSTRB   = 4'b1111;
    WVALID  = 1'b1;
    BREADY  = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    checkOutput("t1_bvalid_after_capture", BVALID, 1'b0);
    tick();
    checkOutput("t1_bvalid_after_commit", BVALID, 1'b1);
    checkOutput("t1_bresp", BRESP, 2'b00);
    tick();
    checkOutput("t1_bvalid_cleared", BVALID, 1'b0);
    axi_read(32'h08, d, r);
    checkOutput("t1_rdata", d, 32'hDEADBEEF);
    checkOutput("t1_rresp", r, 2'b00);
    axi_read(32'h0A, d, r);
    checkOutput("t1_unaligned_rdata", d, 32'hDEADBEEF);

    // Byte-lane merge.
    axi_write(32'h04, 32'h11223344, 4'b1111, r);
    checkOutput("t2_bresp_full", r, 2'b00);
    axi_write(32'h04, 32'hAABBCCDD, 4'b0101, r);
    checkOutput("t2_bresp_lanes", r, 2'b00);
    axi_read(32'h04, d, r);
    checkOutput("t2_rdata", d, 32'h11BB33DD);

    // W three cycles ahead of AW, then B back-pressure.
    applyStimulus(1'b0, 1'b1);
    WDATA  = 32'hCAFEF00D;
    WSTRB  = 4'b1111;
    WVALID = 1'b1;
    tick();
    WVALID = 1'b0;
    checkOutput("t3_wready_held", WREADY, 1'b0);
    tick();
    tick();
    AWADDR  = 32'h0C;
    AWVALID = 1'b1;
    checkOutput("t3_awready_before_aw", AWREADY, 1'b1);
    tick();
    AWVALID = 1'b0;
    checkOutput("t3_bvalid_after_capture", BVALID, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t3_hold%0d", i), {BVALID, AWREADY, WREADY, BRESP}, 5'b10000);
      tick();
    end
    BREADY = 1'b1;
    tick();
    checkOutput("t3_after_b", {BVALID, AWREADY, WREADY}, 3'b011);
    axi_read(32'h0C, d, r);
    checkOutput("t3_rdata", d, 32'hCAFEF00D);

    // Out of range: index bits of 0x40 alias word 0, which must stay zero.
    axi_write(32'h40, 32'hFFFFFFFF, 4'b1111, r);
    checkOutput("t4_bresp", r, 2'b10);
    axi_read(32'h40, d, r);
    checkOutput("t4_rdata", d, 32'h0);
    checkOutput("t4_rresp", r, 2'b10);
    axi_read(32'h00, d, r);
    checkOutput("t4_word0", d, 32'h0);
    checkOutput("t4_word0_resp", r, 2'b00);
    axi_read(32'h08, d, r);
    checkOutput("t4_word2", d, 32'hDEADBEEF);

    // AR handshake on the commit edge returns pre-write data.
    axi_write(32'h08, 32'h1, 4'b1111, r);
    applyStimulus(1'b1, 1'b0);
    AWADDR  = 32'h08;
    AWVALID = 1'b1;
    WDATA   = 32'h2;
    WSTRB   = 4'b1111;
    WVALID  = 1'b1;
    tick();
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    ARADDR  = 32'h08;
    ARVALID = 1'b1;
    checkOutput("t5_arready", ARREADY, 1'b1);
    tick();
    ARVALID = 1'b0;
    checkOutput("t5_both_valid", {RVALID, BVALID}, 2'b11);
    checkOutput("t5_rdata_old", RDATA, 32'h1);
    tick();
    checkOutput("t5_rdata_stable", {RVALID, RDATA}, {1'b1, 32'h1});
    RREADY = 1'b1;
    tick();
    checkOutput("t5_rvalid_cleared", RVALID, 1'b0);
    axi_read(32'h08, d, r);
    checkOutput("t5_rdata_new", d, 32'h2);

    // Reset while a read response is stalled.
    applyStimulus(1'b1, 1'b0);
    ARADDR  = 32'h04;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    checkOutput("t6_rvalid_stalled", RVALID, 1'b1);
    checkOutput("t6_rdata_stalled", RDATA, 32'h11BB33DD);
    ARESET = 1'b1;
    #1;
    checkOutput("t6_arready_in_reset", ARREADY, 1'b0);
    tick();
    checkOutput("t6_outputs_in_reset", {RVALID, ARREADY, AWREADY, WREADY}, 4'b0000);
    ARESET = 1'b0;
    tick();
    checkOutput("t6_no_late_rvalid", RVALID, 1'b0);
    for (int i = 0; i < DEPTH_WORDS; i++) begin
      axi_read(32'(i * 4), d, r);
      checkOutput($sformatf("t6_clear_word%0d", i), {r, d}, 34'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
